// File: rtl/conv_window_feeder_pkg.sv
// Shared definitions for the convolution window feeder: FSM encoding, float16
// element width and the flat window offset used to pack the image bus.
package conv_window_feeder_pkg;

  localparam int FP16_W = 16;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Bit offset of element (channel a, window index b) inside the image bus.
  function automatic int win_offset(input int a, input int b, input int k_l,
                                    input int k_w, input int dw);
    return (a * k_l * k_w + b) * dw;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Single-port delay line of one image row: each write returns the word stored
// at the same column one row earlier.
module conv_line_buffer #(
  parameter int width  = 16,
  parameter int depth  = 8,
  localparam int addr_w = (depth > 1) ? $clog2(depth) : 1
) (
  input  logic              clk,
  input  logic              en,
  input  logic [addr_w-1:0] addr,
  input  logic [width-1:0]  din,
  output logic [width-1:0]  dout
);

  logic [width-1:0] mem [depth];

  assign dout = mem[addr];

  always_ff @(posedge clk) begin
    if (en) mem[addr] <= din;
  end

endmodule

// File: rtl/conv_window_feeder.sv
// Streams raster pixels into line buffers and a K_L x K_W window, hands each
// complete window to a convolution unit and returns its result with coordinates.
module conv_window_feeder
  import conv_window_feeder_pkg::*;
#(
  parameter int data_width    = FP16_W,
  parameter int input_channel = 1,
  parameter int image_length  = 8,
  parameter int image_width   = 8,
  parameter int weight_length = 3,
  parameter int weight_width  = 3,
  localparam int row_w = $clog2(image_length),
  localparam int col_w = $clog2(image_width)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [input_channel*data_width-1:0]    pix_data,
  input  logic                                   pix_valid,
  output logic                                   pix_ready,
  output logic                                   conv_en,
  output logic [0:input_channel*weight_length*weight_width*data_width-1] image,
  input  logic [data_width-1:0]                  cu_result,
  input  logic                                   cu_out_valid,
  output logic [data_width-1:0]                  res_data,
  output logic                                   res_valid,
  output logic [row_w-1:0]                       res_row,
  output logic [col_w-1:0]                       res_col,
  output logic                                   frame_done
);

  localparam int K_L   = weight_length;
  localparam int K_W   = weight_width;
  localparam int pix_w = input_channel * data_width;
  localparam logic [row_w-1:0] row_last = row_w'(image_length - 1);
  localparam logic [col_w-1:0] col_last = col_w'(image_width - 1);

  state_t           state;
  logic [row_w-1:0] row_cnt;
  logic [col_w-1:0] col_cnt;
  logic [row_w-1:0] win_row;
  logic [col_w-1:0] win_col;
  logic             accept;
  logic             complete;
  logic [pix_w-1:0] tap [K_L];
  logic [data_width-1:0] win [input_channel][K_L][K_W];

  assign accept   = pix_valid && pix_ready && (state == FILL);
  assign complete = (row_cnt >= row_w'(K_L - 1)) && (col_cnt >= col_w'(K_W - 1));

  // tap[j] is the current column pixel from j rows above the incoming one.
  assign tap[0] = pix_data;

  for (genvar i = 0; i < K_L - 1; i++) begin : g_lb
    conv_line_buffer #(
      .width(pix_w),
      .depth(image_width)
    ) u_lb (
      .clk (clk),
      .en  (accept),
      .addr(col_cnt),
      .din (tap[i]),
      .dout(tap[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int a = 0; a < input_channel; a++)
        for (int r = 0; r < K_L; r++)
          for (int c = 0; c < K_W; c++)
            win[a][r][c] <= '0;
    end else if (accept) begin
      for (int a = 0; a < input_channel; a++) begin
        for (int r = 0; r < K_L; r++) begin
          for (int c = 0; c < K_W - 1; c++) win[a][r][c] <= win[a][r][c+1];
          win[a][r][K_W-1] <= tap[K_L-1-r][a*data_width +: data_width];
        end
      end
    end
  end

  for (genvar a = 0; a < input_channel; a++) begin : g_ch
    for (genvar r = 0; r < K_L; r++) begin : g_row
      for (genvar c = 0; c < K_W; c++) begin : g_col
        localparam int off = win_offset(a, r * K_W + c, K_L, K_W, data_width);
        assign image[off +: data_width] = win[a][r][c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= FILL;
      row_cnt    <= '0;
      col_cnt    <= '0;
      win_row    <= '0;
      win_col    <= '0;
      pix_ready  <= 1'b0;
      conv_en    <= 1'b0;
      res_valid  <= 1'b0;
      frame_done <= 1'b0;
      res_data   <= '0;
      res_row    <= '0;
      res_col    <= '0;
    end else begin
      res_valid  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        FILL: begin
          pix_ready <= 1'b1;
          if (accept) begin
            if (col_cnt == col_last) begin
              col_cnt <= '0;
              row_cnt <= (row_cnt == row_last) ? '0 : row_cnt + row_w'(1);
            end else begin
              col_cnt <= col_cnt + col_w'(1);
            end
            if (complete) begin
              win_row   <= row_cnt;
              win_col   <= col_cnt;
              pix_ready <= 1'b0;
              conv_en   <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (cu_out_valid) begin
            res_data   <= cu_result;
            res_valid  <= 1'b1;
            res_row    <= win_row - row_w'(K_L - 1);
            res_col    <= win_col - col_w'(K_W - 1);
            frame_done <= (win_row == row_last) && (win_col == col_last);
            conv_en    <= 1'b0;
            state      <= DRAIN;
          end
        end
        // One idle cycle lets the unit drop its valid before new pixels arrive.
        DRAIN: begin
          pix_ready <= 1'b1;
          state     <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench: 4x4 single-channel feeder plus a 5x5 two-channel feeder,
// each with a small convolution-unit responder driven from tasks.
module tb_conv_window_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // 4x4, 1 channel, K=3
  logic              reset;
  logic [15:0]       pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              conv_en;
  logic [0:143]      image;
  logic [15:0]       cu_result;
  logic              cu_out_valid;
  logic [15:0]       res_data;
  logic              res_valid;
  logic [1:0]        res_row;
  logic [1:0]        res_col;
  logic              frame_done;

  // 5x5, 2 channels, K=3
  logic              reset_b;
  logic [31:0]       pix_data_b;
  logic              pix_valid_b;
  logic              pix_ready_b;
  logic              conv_en_b;
  logic [0:287]      image_b;
  logic [15:0]       cu_result_b;
  logic              cu_out_valid_b;
  logic [15:0]       res_data_b;
  logic              res_valid_b;
  logic [2:0]        res_row_b;
  logic [2:0]        res_col_b;
  logic              frame_done_b;

  conv_window_feeder #(
    .data_width(16), .input_channel(1), .image_length(4), .image_width(4),
    .weight_length(3), .weight_width(3)
  ) u_dut (
    .clk(clk), .reset(reset), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .conv_en(conv_en), .image(image),
    .cu_result(cu_result), .cu_out_valid(cu_out_valid), .res_data(res_data),
    .res_valid(res_valid), .res_row(res_row), .res_col(res_col),
    .frame_done(frame_done)
  );

  conv_window_feeder #(
    .data_width(16), .input_channel(2), .image_length(5), .image_width(5),
    .weight_length(3), .weight_width(3)
  ) u_dut_b (
    .clk(clk), .reset(reset_b), .pix_data(pix_data_b), .pix_valid(pix_valid_b),
    .pix_ready(pix_ready_b), .conv_en(conv_en_b), .image(image_b),
    .cu_result(cu_result_b), .cu_out_valid(cu_out_valid_b), .res_data(res_data_b),
    .res_valid(res_valid_b), .res_row(res_row_b), .res_col(res_col_b),
    .frame_done(frame_done_b)
  );

  logic [1:0]   q_row  [$];
  logic [1:0]   q_col  [$];
  logic [15:0]  q_data [$];
  bit           q_fd   [$];
  logic [0:143] q_img  [$];
  int           fd_total;

  // float16 encodings of the integers 0..15
  function automatic logic [15:0] f16(input int i);
    case (i)
      0: return 16'h0000;  1: return 16'h3C00;  2: return 16'h4000;  3: return 16'h4200;
      4: return 16'h4400;  5: return 16'h4500;  6: return 16'h4600;  7: return 16'h4700;
      8: return 16'h4800;  9: return 16'h4880; 10: return 16'h4900; 11: return 16'h4980;
      12: return 16'h4A00; 13: return 16'h4A80; 14: return 16'h4B00; 15: return 16'h4B80;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] pixval(input int idx, input int mode);
    return (mode == 0) ? 16'h3C00 : f16(idx);
  endfunction

  // Feeds pixels first..last and answers each window after 'delay' cycles of
  // conv_en (delay<0: never answers, returns once the pixels are in).
  task automatic stream1(input int first, input int last, input int mode,
                         input int delay, input int want);
    int idx = first;
    int cucnt = 0;
    int lat = 0;
    bit prev_en = 1'b0;
    bit done = 1'b0;
    logic [0:143] held = '0;
    q_row.delete(); q_col.delete(); q_data.delete(); q_fd.delete(); q_img.delete();
    fd_total = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        q_row.push_back(res_row); q_col.push_back(res_col);
        q_data.push_back(res_data); q_fd.push_back(frame_done);
      end
      if (frame_done === 1'b1) fd_total++;
      if (conv_en && !prev_en) begin
        q_img.push_back(image);
        held = image;
        checks++;
        if (pix_ready !== 1'b0) begin
          errors++; $display("FAIL issue_ready got %b want 0", pix_ready);
        end
      end else if (conv_en && prev_en) begin
        checks++;
        if (image !== held || pix_ready !== 1'b0) begin
          errors++; $display("FAIL wait_hold image_stable=%0b pix_ready=%b want stable,0", image === held, pix_ready);
        end
      end
      if (lat == 1) begin
        checks++;
        if (res_valid !== 1'b1 || conv_en !== 1'b0 || pix_ready !== 1'b0) begin
          errors++; $display("FAIL latency_res res_valid=%b conv_en=%b pix_ready=%b want 1,0,0", res_valid, conv_en, pix_ready);
        end
        lat = 2;
      end else if (lat == 2) begin
        checks++;
        if (pix_ready !== 1'b1) begin
          errors++; $display("FAIL latency_ready pix_ready=%b want 1", pix_ready);
        end
        lat = 0;
      end
      prev_en = conv_en;
      if (idx > last && q_row.size() >= want && lat == 0 && (delay < 0 || !conv_en)) begin
        pix_valid = 1'b0; cu_out_valid = 1'b0; done = 1'b1;
        break;
      end
      if (conv_en) cucnt++; else cucnt = 0;
      cu_result = 16'h4880;
      cu_out_valid = (delay >= 0) && conv_en && (cucnt >= delay);
      if (cu_out_valid) lat = 1;
      pix_valid = (idx <= last);
      pix_data = pixval(idx, mode);
      if (pix_valid && pix_ready) idx++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL stream_timeout pixels_sent=%0d want %0d results=%0d want %0d", idx - first, last - first + 1, q_row.size(), want);
      pix_valid = 1'b0; cu_out_valid = 1'b0;
    end
  endtask

  task automatic check_results(input string name);
    checks++;
    if (q_row.size() != 4) begin
      errors++; $display("FAIL %s result_count got %0d want 4", name, q_row.size());
    end
    for (int k = 0; k < q_row.size() && k < 4; k++) begin
      checks++;
      if (q_row[k] !== 2'(k / 2) || q_col[k] !== 2'(k % 2) || q_data[k] !== 16'h4880 || q_fd[k] !== (k == 3)) begin
        errors++;
        $display("FAIL %s result%0d got row=%0d col=%0d data=%h fd=%0b want row=%0d col=%0d data=4880 fd=%0b",
                 name, k, q_row[k], q_col[k], q_data[k], q_fd[k], k / 2, k % 2, k == 3);
      end
    end
    checks++;
    if (fd_total != 1) begin
      errors++; $display("FAIL %s frame_done_count got %0d want 1", name, fd_total);
    end
  endtask

  // Raster-valued frame: window k has bottom-right pixel (k/2+2, k%2+2).
  task automatic check_windows(input string name);
    logic [0:143] w;
    logic [15:0] e;
    int p;
    checks++;
    if (q_img.size() != 4) begin
      errors++; $display("FAIL %s window_count got %0d want 4", name, q_img.size());
    end
    for (int k = 0; k < q_img.size() && k < 4; k++) begin
      w = q_img[k];
      checks++;
      for (int b = 0; b < 9; b++) begin
        p = (k / 2 + b / 3) * 4 + (k % 2 + b % 3);
        e = w[b*16 +: 16];
        if (e !== f16(p)) begin
          errors++; $display("FAIL %s window%0d elem%0d got %h want %h", name, k, b, e, f16(p));
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; reset_b = 1'b0;
    pix_valid = 1'b0; pix_data = '0; cu_out_valid = 1'b0; cu_result = '0;
    pix_valid_b = 1'b0; pix_data_b = '0; cu_out_valid_b = 1'b0; cu_result_b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (pix_ready !== 1'b0 || conv_en !== 1'b0 || res_valid !== 1'b0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl ready=%b conv_en=%b res_valid=%b frame_done=%b want 0,0,0,0", pix_ready, conv_en, res_valid, frame_done);
    end
    checks++;
    if (res_data !== 16'h0 || res_row !== 2'd0 || res_col !== 2'd0 || image !== '0) begin
      errors++; $display("FAIL reset_data res_data=%h row=%0d col=%0d image_zero=%0b want 0,0,0,1", res_data, res_row, res_col, image === '0);
    end
    checks++;
    if (pix_ready_b !== 1'b0 || conv_en_b !== 1'b0 || image_b !== '0) begin
      errors++; $display("FAIL reset_b ready=%b conv_en=%b image_zero=%0b want 0,0,1", pix_ready_b, conv_en_b, image_b === '0);
    end
    reset = 1'b1; reset_b = 1'b1;
    @(negedge clk);
    checks++;
    if (pix_ready !== 1'b1 || pix_ready_b !== 1'b1) begin
      errors++; $display("FAIL reset_release pix_ready=%b pix_ready_b=%b want 1,1", pix_ready, pix_ready_b);
    end
  endtask

  task automatic test_constant_frame();
    stream1(0, 15, 0, 5, 4);
    check_results("const");
    checks++;
    if (q_img.size() < 1 || q_img[0] !== {9{16'h3C00}}) begin
      errors++; $display("FAIL const_window got %h want all 3c00", (q_img.size() > 0) ? q_img[0] : '0);
    end
  endtask

  task automatic test_raster_window();
    logic [15:0] exp0 [9] = '{16'h0000, 16'h3C00, 16'h4000, 16'h4400, 16'h4500,
                              16'h4600, 16'h4800, 16'h4880, 16'h4900};
    logic [0:143] w;
    stream1(0, 15, 1, 5, 4);
    w = (q_img.size() > 0) ? q_img[0] : '0;
    for (int b = 0; b < 9; b++) begin
      checks++;
      if (w[b*16 +: 16] !== exp0[b]) begin
        errors++; $display("FAIL first_window elem%0d got %h want %h", b, w[b*16 +: 16], exp0[b]);
      end
    end
    check_windows("raster");
    check_results("raster");
  endtask

  task automatic test_stall();
    stream1(0, 15, 1, 22, 4);
    check_windows("stall");
    check_results("stall");
  endtask

  task automatic test_fill_pulse();
    stream1(0, 4, 1, -1, 0);
    @(negedge clk);
    cu_result = 16'h1234;
    cu_out_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      cu_out_valid = 1'b0;
      checks++;
      if (res_valid !== 1'b0 || conv_en !== 1'b0 || pix_ready !== 1'b1) begin
        errors++; $display("FAIL fill_pulse cyc%0d res_valid=%b conv_en=%b pix_ready=%b want 0,0,1", i, res_valid, conv_en, pix_ready);
      end
    end
    stream1(5, 15, 1, 5, 4);
    check_windows("fill_pulse");
    check_results("fill_pulse");
  endtask

  task automatic test_reset_wait();
    stream1(0, 10, 1, -1, 0);
    @(negedge clk);
    checks++;
    if (conv_en !== 1'b1 || pix_ready !== 1'b0) begin
      errors++; $display("FAIL pre_reset_wait conv_en=%b pix_ready=%b want 1,0", conv_en, pix_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (conv_en !== 1'b0 || res_valid !== 1'b0 || pix_ready !== 1'b0 || image !== '0) begin
      errors++; $display("FAIL reset_in_wait conv_en=%b res_valid=%b pix_ready=%b image_zero=%0b want 0,0,0,1", conv_en, res_valid, pix_ready, image === '0);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (pix_ready !== 1'b1 || res_valid !== 1'b0 || conv_en !== 1'b0) begin
      errors++; $display("FAIL after_reset pix_ready=%b res_valid=%b conv_en=%b want 1,0,0", pix_ready, res_valid, conv_en);
    end
    stream1(0, 15, 1, 5, 4);
    check_windows("fresh_frame");
    check_results("fresh_frame");
  endtask

  task automatic test_two_channel();
    int idx = 0;
    int cucnt = 0;
    int nres = 0;
    int issues = 0;
    int fd = 0;
    bit prev = 1'b0;
    bit done = 1'b0;
    bit ok;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      if (res_valid_b === 1'b1) begin
        checks++;
        if (res_row_b !== 3'(nres / 3) || res_col_b !== 3'(nres % 3) || res_data_b !== 16'h4200 || frame_done_b !== (nres == 8)) begin
          errors++; $display("FAIL two_ch_result%0d got row=%0d col=%0d data=%h fd=%b want row=%0d col=%0d data=4200 fd=%0b",
                             nres, res_row_b, res_col_b, res_data_b, frame_done_b, nres / 3, nres % 3, nres == 8);
        end
        nres++;
      end
      if (frame_done_b === 1'b1) fd++;
      if (conv_en_b && !prev) begin
        issues++;
        checks++;
        if (image_b[144:159] !== 16'h4000 || image_b[0:15] !== 16'h3C00) begin
          errors++; $display("FAIL two_ch_slices issue%0d got [144:159]=%h [0:15]=%h want 4000,3c00", issues, image_b[144:159], image_b[0:15]);
        end
        ok = 1'b1;
        for (int b = 0; b < 9; b++)
          if (image_b[b*16 +: 16] !== 16'h3C00 || image_b[144 + b*16 +: 16] !== 16'h4000) ok = 1'b0;
        checks++;
        if (!ok) begin
          errors++; $display("FAIL two_ch_window issue%0d got %h want ch0=3c00 ch1=4000", issues, image_b);
        end
      end
      prev = conv_en_b;
      if (idx >= 25 && nres >= 9 && !conv_en_b) begin
        pix_valid_b = 1'b0; cu_out_valid_b = 1'b0; done = 1'b1;
        break;
      end
      if (conv_en_b) cucnt++; else cucnt = 0;
      cu_result_b = 16'h4200;
      cu_out_valid_b = conv_en_b && (cucnt >= 3);
      pix_valid_b = (idx < 25);
      pix_data_b = {16'h4000, 16'h3C00};
      if (pix_valid_b && pix_ready_b) idx++;
    end
    checks++;
    if (!done || nres != 9 || issues != 9 || fd != 1) begin
      errors++; $display("FAIL two_ch_counts done=%0b results=%0d issues=%0d frame_done=%0d want 1,9,9,1", done, nres, issues, fd);
      pix_valid_b = 1'b0; cu_out_valid_b = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_constant_frame();
    test_raster_window();
    test_stall();
    test_fill_pulse();
    test_reset_wait();
    test_two_channel();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_window_feeder.md
CONV_WINDOW_FEEDER -- requirements
Module: conv_window_feeder

Interface
REQ-001 Parameter data_width, default 16, float16 element width in bits.
REQ-002 Parameter input_channel, default 1, channels per pixel.
REQ-003 Parameter image_length, default 8, rows per frame.
REQ-004 Parameter image_width, default 8, columns per frame.
REQ-005 Parameter weight_length / weight_width, default 3 / 3, window rows / columns (K_L, K_W).
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-low reset (asserted when 0).
REQ-008 pix_data  in  input_channel*data_width  one raster-order pixel, channel 0 in the low slice.
REQ-009 pix_valid / pix_ready  in / out  1 / 1  pixel handshake; transfer when both are 1.
REQ-010 conv_en  out  1  enable to the convolution unit.
REQ-011 image  out  [0:input_channel*K_L*K_W*data_width-1]  window. Element (channel a, index b=row*K_W+col, row 0 top) is at offset a*K_L*K_W*data_width + b*data_width, width data_width.
REQ-012 cu_result / cu_out_valid  in / in  data_width / 1  result and valid from the convolution unit.
REQ-013 res_data / res_valid  out / out  data_width / 1  captured result plus a 1-cycle strobe; no backpressure.
REQ-014 res_row / res_col  out / out  clog2(image_length) / clog2(image_width)  output-map coordinates of res_data.
REQ-015 frame_done  out  1  1-cycle pulse after the last window result of a frame.

Function
REQ-016 FSM states: FILL, ISSUE, WAIT, DRAIN.
REQ-017 FILL: pix_ready=1, conv_en=0.
- Each accepted pixel is written into K_L-1 line buffers of image_width entries and into a K_L x K_W shift window.
- The input row and column counters advance.
REQ-018 Window-complete condition: the accepted pixel has row >= K_L-1 and col >= K_W-1. On that acceptance the FSM goes to ISSUE; otherwise it stays in FILL.
REQ-019 ISSUE, one cycle after the triggering accept:
- image holds the window whose bottom-right corner is that pixel.
- conv_en=1 and pix_ready=0.
- The FSM goes to WAIT.
REQ-020 WAIT: conv_en=1, image held stable, pix_ready=0 until cu_out_valid=1 is sampled.
REQ-021 On the WAIT edge where cu_out_valid=1:
- res_data<=cu_result, res_valid<=1.
- res_row<=pixel row-(K_L-1), res_col<=pixel col-(K_W-1).
- conv_en<=0; the FSM goes to DRAIN.
REQ-022 DRAIN lasts exactly one cycle with conv_en=0 so the unit clears its valid. The FSM then returns to FILL with pix_ready=1.
REQ-023 Latency: res_valid rises 1 cycle after cu_out_valid is sampled. pix_ready returns 2 cycles after that sample.
REQ-024 cu_out_valid is ignored in FILL, ISSUE and DRAIN.
REQ-025 Column wrap: at col=image_width-1 the column counter goes to 0 and the row counter increments. Window shift registers keep no stale columns across rows; only windows with col >= K_W-1 are issued.
REQ-026 Frame end: when the last window's result is captured (pixel row=image_length-1, col=image_width-1), frame_done pulses together with res_valid.
- Row and column counters then return to 0.
- The next pixel starts a new frame; line-buffer contents are don't-care.
REQ-027 Results per frame are exactly (image_length-K_L+1)*(image_width-K_W+1), in raster order.

Reset
REQ-028 While reset=0 on a clock edge:
- State is FILL; counters are 0.
- pix_ready=0, conv_en=0, res_valid=0, frame_done=0.
- res_data=0, res_row=0, res_col=0, image=0.
REQ-029 pix_ready rises in the first cycle after reset=1 is sampled.
REQ-030 Reset in ISSUE or WAIT drops conv_en on that edge, discards the pending window, and produces no res_valid.
REQ-031 Line-buffer RAM contents are not reset.

Structure
REQ-032 The FSM state encoding and the float16 width constant live in the shared conv package. The window index arithmetic (a*K_L*K_W+b)*data_width is a package function.
REQ-033 One sub-module, conv_line_buffer: a single-port, image_width-deep delay line, instantiated K_L-1 times.

Verification
REQ-034 4x4 frame, K=3, 1 channel, every pixel 16'h3C00, unit model returns 16'h4880 after 5 cycles:
- 4 res_valid pulses with (row,col) = (0,0), (0,1), (1,0), (1,1).
- frame_done on the 4th pulse.
REQ-035 4x4 frame with pixel value = raster index (float16 of 0..15): the first image window equals pixels 0,1,2,4,5,6,8,9,10 in element order 0..8.
REQ-036 cu_out_valid held 0 for 20 cycles in WAIT:
- conv_en stays 1, image stays stable, pix_ready stays 0.
- pix_valid held 1 during the stall loses no pixel.
REQ-037 reset=0 for one cycle in WAIT:
- conv_en=0 on the next cycle; no res_valid.
- A fresh frame afterwards yields exactly 4 results.
REQ-038 cu_out_valid pulsed in FILL: no res_valid and no state change.
REQ-039 2-channel, 5x5 frame, channel 1 = 16'h4000, channel 0 = 16'h3C00:
- 9 results.
- image bits [144:159] = 16'h4000 and [0:15] = 16'h3C00 on every issue.
